// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants for the thresholded FIFO (fifo_umbral) and its storage
// array (fifo_mem).
//   DATA_WIDTH    : default width of each stored word
//   ADDR_WIDTH    : default log2 of the FIFO depth
//   UMBRALES_L_H  : default width of the packed {umbral_H, umbral_L} word
//   DEPTH         : number of entries for the default ADDR_WIDTH
//   UMB_W         : width of one threshold half
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DATA_WIDTH   = 6;
    localparam int ADDR_WIDTH   = 2;
    localparam int UMBRALES_L_H = 8;

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int UMB_W = UMBRALES_L_H / 2;

    // Width wide enough to compare an occupancy count against a threshold
    // half without losing bits from either operand.
    function automatic int cmp_width(input int cnt_w, input int umb_w);
        return (cnt_w > umb_w) ? cnt_w : umb_w;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// Register array with one synchronous write port and one registered read
// port. The read register is reset to zero; the array itself is not.
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset (read register only)
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_en_i   : read strobe; rd_data_o loads mem[rd_addr_i] on the edge
//   rd_addr_i : read address
//   rd_data_o : registered read data, holds its value when rd_en_i is low
// ---------------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = ADDR_WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    localparam int NWORDS = 1 << AW;

    logic [DW-1:0] mem_q [NWORDS];
    logic [DW-1:0] rd_data_q;

    // The array is deliberately left out of the reset domain.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Reading and writing the same address on one edge returns the old
    // word, which is what a full FIFO doing push+pop needs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_umbral.sv
// ---------------------------------------------------------------------------
// fifo_umbral
// Single-clock FIFO with programmable almost-empty / almost-full thresholds
// and a sticky overflow/underflow error flag.
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   push/data_in : write request and data
//   pop          : read request
//   data_out     : registered read data (1-cycle latency after pop)
//   valid_out    : high for one cycle when data_out carries a popped word
//   umbral_LH    : {umbral_H, umbral_L} threshold word
//   empty/full   : count == 0 / count == depth
//   almost_empty : count <= umbral_L
//   almost_full  : count >= umbral_H
//   error        : sticky, set on rejected push or pop, cleared by reset
//   count        : occupancy 0..depth
//
// Request semantics: push and pop are single-cycle requests sampled on the
// rising edge; there is no ready back-pressure. A pop is accepted when the
// FIFO is not empty. A push is accepted when the FIFO is not full, or when
// it is full and the same edge also accepts a pop. A rejected request has
// no effect other than setting error.
// ---------------------------------------------------------------------------
module fifo_umbral
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = fifo_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH   = fifo_pkg::ADDR_WIDTH,
    parameter int UMBRALES_L_H = fifo_pkg::UMBRALES_L_H
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    input  logic [UMBRALES_L_H-1:0] umbral_LH,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic                    error,
    output logic [ADDR_WIDTH:0]     count
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int HW    = UMBRALES_L_H / 2;
    localparam int CMP_W = cmp_width(CNT_W, HW);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(1 << ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  error_q, error_d;
    logic                  valid_q, valid_d;

    logic push_ok;
    logic pop_ok;
    logic is_empty;
    logic is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);

    // A full FIFO frees its slot on the same edge a pop is accepted, so a
    // simultaneous push can land in it. An empty FIFO never bypasses.
    assign pop_ok  = pop && !is_empty;
    assign push_ok = push && (!is_full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        error_d  = error_q;
        valid_d  = pop_ok;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if ((push && !push_ok) || (pop && !pop_ok)) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
            valid_q  <= valid_d;
        end
    end

    // Write is blocked while reset is high so no partial write can land.
    fifo_mem #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH)
    ) u_mem (
        .clk_i     (clk),
        .rst_i     (reset),
        .wr_en_i   (push_ok && !reset),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (data_in),
        .rd_en_i   (pop_ok && !reset),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (data_out)
    );

    // Thresholds are compared unsigned at a width that holds both operands,
    // so umbral_L >= depth keeps almost_empty high and umbral_H == 0 keeps
    // almost_full high.
    logic [HW-1:0]    umb_l, umb_h;
    logic [CMP_W-1:0] cnt_x, umb_l_x, umb_h_x;

    assign umb_l   = umbral_LH[HW-1:0];
    assign umb_h   = umbral_LH[2*HW-1:HW];
    assign cnt_x   = CMP_W'(count_q);
    assign umb_l_x = CMP_W'(umb_l);
    assign umb_h_x = CMP_W'(umb_h);

    assign empty        = is_empty;
    assign full         = is_full;
    assign almost_empty = (cnt_x <= umb_l_x);
    assign almost_full  = (cnt_x >= umb_h_x);
    assign error        = error_q;
    assign valid_out    = valid_q;
    assign count        = count_q;

endmodule

// File: tb/tb_fifo_umbral.sv
// ---------------------------------------------------------------------------
// tb_fifo_umbral
// Directed bench for fifo_umbral: reset values, threshold flags, overflow,
// underflow, full push+pop, empty push+pop, async reset and pointer wrap.
// ---------------------------------------------------------------------------
module tb_fifo_umbral;

    logic       clk;
    logic       reset;
    logic       push;
    logic [5:0] data_in;
    logic       pop;
    logic [5:0] data_out;
    logic       valid_out;
    logic [7:0] umbral_LH;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic       error;
    logic [2:0] count;

    int total;
    int bad;

    fifo_umbral dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .umbral_LH    (umbral_LH),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .error        (error),
        .count        (count)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of requests, then sample 1 time unit after the edge.
    task automatic cyc(input logic ps, input logic [5:0] d, input logic pp);
        push    = ps;
        data_in = d;
        pop     = pp;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0] vals [4];
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        data_in   = '0;
        umbral_LH = 8'h31;
        vals[0] = 6'h0A; vals[1] = 6'h0B; vals[2] = 6'h0C; vals[3] = 6'h0D;

        // reset state
        @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_afull", almost_full, 0);
        chk("rst_error", error, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_dout", data_out, 0);
        reset = 1'b0;

        // fill with L=1, H=3
        cyc(1, 6'h0A, 0);
        chk("f1_count", count, 1);
        chk("f1_aempty", almost_empty, 1);
        chk("f1_afull", almost_full, 0);
        cyc(1, 6'h0B, 0);
        chk("f2_count", count, 2);
        chk("f2_aempty", almost_empty, 0);
        chk("f2_afull", almost_full, 0);
        cyc(1, 6'h0C, 0);
        chk("f3_count", count, 3);
        chk("f3_afull", almost_full, 1);
        chk("f3_full", full, 0);
        cyc(1, 6'h0D, 0);
        chk("f4_count", count, 4);
        chk("f4_full", full, 1);
        chk("f4_afull", almost_full, 1);
        chk("f4_error", error, 0);

        // overflow
        cyc(1, 6'h3F, 0);
        chk("ovf_error", error, 1);
        chk("ovf_count", count, 4);

        // threshold corners: L=15 (>= depth), H=0
        umbral_LH = 8'h0F;
        #1;
        chk("umb_aempty_sat", almost_empty, 1);
        chk("umb_afull_h0", almost_full, 1);
        umbral_LH = 8'h31;
        #1;
        chk("umb_aempty_back", almost_empty, 0);

        // drain in order
        for (int i = 0; i < 4; i++) begin
            cyc(0, 6'h00, 1);
            chk("drain_valid", valid_out, 1);
            chk("drain_data", data_out, 32'(vals[i]));
            chk("drain_count", count, 32'(3 - i));
            cyc(0, 6'h00, 0);
            chk("idle_valid", valid_out, 0);
            chk("idle_hold", data_out, 32'(vals[i]));
        end
        chk("drain_empty", empty, 1);

        // async reset with count=3, error=1, data_out=0x0D
        cyc(1, 6'h01, 0);
        cyc(1, 6'h02, 0);
        cyc(1, 6'h03, 0);
        chk("pre_rst_count", count, 3);
        reset = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_dout", data_out, 0);
        chk("arst_valid", valid_out, 0);
        chk("arst_error", error, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // full push+pop
        for (int i = 0; i < 4; i++) cyc(1, vals[i], 0);
        chk("full2_count", count, 4);
        cyc(1, 6'h15, 1);
        chk("fpp_valid", valid_out, 1);
        chk("fpp_data", data_out, 32'h0A);
        chk("fpp_count", count, 4);
        chk("fpp_error", error, 0);
        cyc(0, 6'h00, 1);
        chk("fpp_d1", data_out, 32'h0B);
        cyc(0, 6'h00, 1);
        chk("fpp_d2", data_out, 32'h0C);
        cyc(0, 6'h00, 1);
        chk("fpp_d3", data_out, 32'h0D);
        cyc(0, 6'h00, 1);
        chk("fpp_d4", data_out, 32'h15);
        chk("fpp_v4", valid_out, 1);
        chk("fpp_empty", count, 0);

        // underflow pop alone
        cyc(0, 6'h00, 1);
        chk("udf_valid", valid_out, 0);
        chk("udf_hold", data_out, 32'h15);
        chk("udf_error", error, 1);

        // empty push+pop
        do_reset();
        cyc(1, 6'h22, 1);
        chk("epp_count", count, 1);
        chk("epp_valid", valid_out, 0);
        chk("epp_error", error, 1);
        cyc(0, 6'h00, 1);
        chk("epp_data", data_out, 32'h22);
        chk("epp_dvalid", valid_out, 1);
        chk("epp_count2", count, 0);

        // wrap-around
        do_reset();
        for (int v = 1; v <= 10; v++) begin
            cyc(1, 6'(v), 0);
            chk("wrap_cnt1", count, 1);
            cyc(0, 6'h00, 1);
            chk("wrap_data", data_out, 32'(v));
            chk("wrap_valid", valid_out, 1);
            chk("wrap_cnt0", count, 0);
        end
        chk("wrap_error", error, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
